// File: rtl/addr_stack_if.sv
// addr_stack_if: control/address bundle between the fsm/timing control
// (master) and the program-counter stack (slave).
interface addr_stack_if #(
  parameter int WIDTH = 14,
  parameter int PTR_W = 3
);
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [PTR_W-1:0] rd_idx;
  logic             err_clr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rd_data;
  logic [PTR_W-1:0] level;
  logic             overflow;
  logic             underflow;

  modport master (
    output op, din, rd_idx, err_clr,
    input  pc, rd_data, level, overflow, underflow
  );

  modport slave (
    input  op, din, rd_idx, err_clr,
    output pc, rd_data, level, overflow, underflow
  );
endinterface

// File: rtl/addr_stack.sv
// addr_stack: rotating program-counter / return-address stack.
// The active PC is mem[sp]; CALL/RET move sp instead of copying entries.
// Optional feature macro: ADDR_STACK_GUARD_EN
//   defined   -> CALL when full / RET when empty are ignored and raise
//                sticky overflow / underflow flags (cleared by err_clr).
//   undefined -> sp and level wrap silently; flags tied to 0.
module addr_stack #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  addr_stack_if.slave bus
);

  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] sp_inc;
  logic [PTR_W-1:0] rd_ptr;
  logic             is_call, is_ret;
  logic             call_ok, ret_ok;

  assign is_call = (bus.op == OP_CALL);
  assign is_ret  = (bus.op == OP_RET);
  assign sp_inc  = sp_q + 1'b1;

`ifdef ADDR_STACK_GUARD_EN
  localparam logic [PTR_W-1:0] LEVEL_FULL = PTR_W'(DEPTH - 1);

  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A blocked push/pop is simply dropped; only the flag records it.
  assign call_ok = (level_q != LEVEL_FULL);
  assign ret_ok  = (level_q != '0);

  // Sticky error flags: a new event in the same cycle beats err_clr.
  always_comb begin
    overflow_d  = (overflow_q  & ~bus.err_clr) | (is_call & ~call_ok);
    underflow_d = (underflow_q & ~bus.err_clr) | (is_ret  & ~ret_ok);
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  logic unused_err_clr;

  // Original behaviour: pointer and level wrap, oldest entry is overwritten.
  assign call_ok        = 1'b1;
  assign ret_ok         = 1'b1;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

  // Next-state for entries, pointer and nesting level from the current op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    sp_d    = sp_q;
    level_d = level_q;
    case (bus.op)
      OP_INC:  mem_d[sp_q] = mem_q[sp_q] + 1'b1;
      OP_JMP:  mem_d[sp_q] = bus.din;
      OP_CALL: begin
        if (call_ok) begin
          sp_d          = sp_inc;
          mem_d[sp_inc] = bus.din;
          level_d       = level_q + 1'b1;
        end
      end
      OP_RET: begin
        if (ret_ok) begin
          sp_d    = sp_q - 1'b1;
          level_d = level_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stack state registers; reset clears every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      sp_q    <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      sp_q    <= sp_d;
      level_q <= level_d;
    end
  end

  // Peek is a pure read of the registers; index wraps mod DEPTH.
  assign rd_ptr      = sp_q - bus.rd_idx;
  assign bus.rd_data = mem_q[rd_ptr];
  assign bus.pc      = mem_q[sp_q];
  assign bus.level   = level_q;

endmodule

// File: tb/tb_addr_stack.sv
// tb_addr_stack: scoreboard bench for addr_stack. The driver steps a
// reference model at each issued op and queues the expected post-edge view;
// a monitor pops and compares one entry after every rising edge.
module tb_addr_stack;
  localparam int WIDTH = 14;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  localparam logic [2:0] NOP = 3'b000, INC = 3'b001, JMP = 3'b010,
                         CALL = 3'b011, RET = 3'b100;

`ifdef ADDR_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rd;
    logic [PTR_W-1:0] lvl;
    logic             ovf;
    logic             unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  addr_stack_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

  addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: stack as an array addressed by a modular pointer.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_sp;
  int               m_lvl;
  bit               m_ovf, m_unf;
  exp_t             sb_q[$];

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sp = 0; m_lvl = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic logic [WIDTH-1:0] model_peek(int ri);
    return m_mem[(m_sp - ri + DEPTH) % DEPTH];
  endfunction

  function automatic void model_step(logic [2:0] o, logic [WIDTH-1:0] d, logic clr);
    bit ev_o = 0, ev_u = 0;
    case (o)
      INC: m_mem[m_sp] = m_mem[m_sp] + 1'b1;
      JMP: m_mem[m_sp] = d;
      CALL: begin
        if (GUARD && m_lvl == DEPTH - 1) ev_o = 1;
        else begin
          m_sp = (m_sp + 1) % DEPTH;
          m_mem[m_sp] = d;
          m_lvl = (m_lvl + 1) % DEPTH;
        end
      end
      RET: begin
        if (GUARD && m_lvl == 0) ev_u = 1;
        else begin
          m_sp  = (m_sp + DEPTH - 1) % DEPTH;
          m_lvl = (m_lvl + DEPTH - 1) % DEPTH;
        end
      end
      default: ;
    endcase
    if (GUARD) begin
      m_ovf = ev_o | (m_ovf & ~clr);
      m_unf = ev_u | (m_unf & ~clr);
    end
  endfunction

  // Drive one op; check the combinational peek against pre-edge state,
  // then queue the expected post-edge outputs.
  task automatic issue(logic [2:0] o, logic [WIDTH-1:0] d, logic [PTR_W-1:0] ri, logic clr);
    exp_t e;
    @(negedge clk);
    bus.op = o; bus.din = d; bus.rd_idx = ri; bus.err_clr = clr;
    #1;
    chk("peek_comb", int'(bus.rd_data), int'(model_peek(int'(ri))));
    model_step(o, d, clr);
    e.pc  = m_mem[m_sp];
    e.rd  = model_peek(int'(ri));
    e.lvl = PTR_W'(m_lvl);
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("pc", int'(bus.pc), int'(e.pc));
      chk("rd_data", int'(bus.rd_data), int'(e.rd));
      chk("level", int'(bus.level), int'(e.lvl));
      chk("overflow", int'(bus.overflow), int'(e.ovf));
      chk("underflow", int'(bus.underflow), int'(e.unf));
      $display("op=%0d pc=%0h level=%0d ovf=%0b unf=%0b", bus.op, bus.pc, bus.level,
               bus.overflow, bus.underflow);
    end
  end

  // Wait until the previous op's result is visible, then compare to constants.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic peek_const(string name, logic [PTR_W-1:0] ri, int req);
    @(negedge clk);
    bus.op = NOP; bus.err_clr = 1'b0; bus.rd_idx = ri;
    #1;
    chk(name, int'(bus.rd_data), req);
  endtask

  // Assert reset between edges with an INC pending; state must clear at once.
  task automatic async_reset();
    @(negedge clk);
    bus.op = INC; bus.err_clr = 1'b0; bus.rd_idx = '0;
    #2;
    reset = 1'b1;
    bus.op = NOP;
    #1;
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_flags", int'({bus.overflow, bus.underflow}), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.op = NOP; bus.din = '0; bus.rd_idx = '0; bus.err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_pc", int'(bus.pc), 0);
    chk("init_rd", int'(bus.rd_data), 0);
    chk("init_level", int'(bus.level), 0);
    reset = 1'b0;

    // Three increments, then asynchronous reset mid-cycle.
    repeat (3) issue(INC, '0, '0, 1'b0);
    settle();
    chk("inc3_pc", int'(bus.pc), 3);
    chk("inc3_level", int'(bus.level), 0);
    async_reset();
    issue(NOP, '0, '0, 1'b0);
    settle();
    chk("abort_pc", int'(bus.pc), 0);

    // Address wrap.
    issue(JMP, 14'h3FFF, '0, 1'b0);
    issue(INC, '0, '0, 1'b0);
    settle();
    chk("wrap_pc", int'(bus.pc), 0);

    // Nested calls and returns.
    issue(JMP, 14'h0100, '0, 1'b0);
    issue(CALL, 14'h2000, '0, 1'b0);
    issue(CALL, 14'h3000, '0, 1'b0);
    settle();
    chk("call2_pc", int'(bus.pc), 'h3000);
    chk("call2_level", int'(bus.level), 2);
    peek_const("peek1", 3'd1, 'h2000);
    peek_const("peek2", 3'd2, 'h0100);
    issue(RET, '0, '0, 1'b0);
    issue(RET, '0, '0, 1'b0);
    settle();
    chk("ret2_pc", int'(bus.pc), 'h0100);
    chk("ret2_level", int'(bus.level), 0);

    async_reset();
    if (GUARD) begin
      for (int i = 1; i <= 7; i++) issue(CALL, WIDTH'(i * 16), '0, 1'b0);
      issue(CALL, 14'h1234, '0, 1'b0);
      settle();
      chk("full_level", int'(bus.level), 7);
      chk("full_pc", int'(bus.pc), 7 * 16);
      chk("full_ovf", int'(bus.overflow), 1);
      issue(NOP, '0, '0, 1'b1);
      settle();
      chk("clr_ovf", int'(bus.overflow), 0);
      async_reset();
      issue(RET, '0, '0, 1'b0);
      settle();
      chk("empty_pc", int'(bus.pc), 0);
      chk("empty_unf", int'(bus.underflow), 1);
      issue(RET, '0, '0, 1'b1);
      settle();
      chk("unf_wins", int'(bus.underflow), 1);
    end else begin
      for (int i = 1; i <= 8; i++) issue(CALL, WIDTH'(i), '0, 1'b0);
      settle();
      chk("wrap_level", int'(bus.level), 0);
      chk("wrap_call_pc", int'(bus.pc), 8);
      chk("wrap_flags", int'({bus.overflow, bus.underflow}), 0);
      peek_const("peek7", 3'd7, 1);
    end

    // Randomized traffic, biased toward CALL/RET so both boundaries are hit.
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [2:0] o;
      r = int'($urandom_range(0, 99));
      if (r < 30)      o = CALL;
      else if (r < 60) o = RET;
      else             o = 3'($urandom_range(0, 7));
      if (n % 500 == 499) async_reset();
      issue(o, WIDTH'($urandom), PTR_W'($urandom), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
